// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two requesters share one car/cdr
// memory unit, with at most one memory transaction outstanding at a time.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that exceeds
// TIMEOUT cycles (ack with rdata=0, err=1). Without it, WAIT never times out.

`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_arbiter #(
    parameter int DATA_W  = `MEMORY_DATA_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              op0,
    input  logic              op1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_car,
    output logic              mem_cdr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t state;
    logic   last_served;   // id of the requester that completed most recently
    logic   cur_id;        // id of the requester owning the current transaction
    logic   grant;         // requester that wins if arbitration happens now
    logic   grant_op;

    // A zero or negative limit would make every WAIT abort immediately.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // Round-robin: a lone requester wins; on a tie the one not served last wins.
    assign grant    = req1 & (~req0 | ~last_served);
    assign grant_op = grant ? op1 : op0;

    // Control FSM with registered strobes, acks and result data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            cur_id      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mem_car     <= 1'b0;
            mem_cdr     <= 1'b0;
            rdata       <= '0;
            mem_data_in <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err         <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            mem_car <= 1'b0;
            mem_cdr <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cur_id      <= grant;
                        mem_data_in <= grant ? wdata1 : wdata0;
                        mem_car     <= ~grant_op;
                        mem_cdr     <= grant_op;
                        state       <= CMD;
                    end
                end
                CMD: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                    if (mem_ready) begin
                        rdata <= mem_data_out;
`ifdef MEM_ARB_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                        ack0  <= ~cur_id;
                        ack1  <= cur_id;
                        state <= ACK;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt == LAST_CNT) begin
                        // Memory never answered: complete with an aborted result.
                        rdata <= '0;
                        err   <= 1'b1;
                        ack0  <= ~cur_id;
                        ack1  <= cur_id;
                        state <= ACK;
                    end
`endif
                end
                ACK: begin
                    last_served <= cur_id;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then a long
// randomized run checked every cycle against a transaction-level model.

module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int MAXD = TO + 3;
`else
    localparam int MAXD = 5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, op0, op1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err, mem_car, mem_cdr, mem_ready;
    logic [DW-1:0] rdata, mem_data_in, mem_data_out;

    int checks   = 0;
    int failures = 0;

    // expectations for the current cycle, written by the model process
    logic          chk_en = 1'b0;
    logic          e_ack0, e_ack1, e_car, e_cdr, chk_rd, chk_din, e_err;
    logic [DW-1:0] e_rd, e_din;

    mem_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .mem_car(mem_car), .mem_cdr(mem_cdr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model during the random phase.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack0", 32'(ack0), 32'(e_ack0));
            check("ack1", 32'(ack1), 32'(e_ack1));
            check("mem_car", 32'(mem_car), 32'(e_car));
            check("mem_cdr", 32'(mem_cdr), 32'(e_cdr));
            if (chk_rd) begin
                check("rdata", 32'(rdata), 32'(e_rd));
                check("err", 32'(err), 32'(e_err));
            end
            if (chk_din) check("mem_data_in", 32'(mem_data_in), 32'(e_din));
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // One transaction from requester 0 with no answer, or an answer in the 8th WAIT cycle.
    task automatic timeout_run(input bit rdy_last, input logic [DW-1:0] d);
        step(); req0 = 1'b1; op0 = 1'b1; wdata0 = 16'h0055;
        step();
        sample(); check("to_strobe", 32'(mem_cdr), 32'd1);
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k == TO && rdy_last) begin mem_ready = 1'b1; mem_data_out = d; end
            sample(); check("to_noack_early", 32'(ack0), 32'd0);
        end
        step(); mem_ready = 1'b0;
        sample();
        check("to_ack", 32'(ack0), 32'd1);
        check("to_err", 32'(err), rdy_last ? 32'd0 : 32'd1);
        check("to_rdata", 32'(rdata), rdy_last ? 32'(d) : 32'd0);
        step(); req0 = 1'b0;
    endtask
`endif

    // model state (transaction level)
    bit            busy, last, prev_rst, pend [2], pop [2];
    logic [DW-1:0] pdat [2], ptr, ack_data;
    bit            cur_id, cur_op, ack_err;
    int            strobe_cyc, ready_cyc, ack_cyc;
    int            got_order [4];
    int            exp_order [4] = '{0, 1, 0, 1};
    int            n;
    bit            saw;

    initial begin
        rst = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        wdata0 = '0; wdata1 = '0; mem_ready = 0; mem_data_out = '0;

        // reset values
        step();
        sample();
        check("rst_ack0", 32'(ack0), 0); check("rst_ack1", 32'(ack1), 0);
        check("rst_car", 32'(mem_car), 0); check("rst_cdr", 32'(mem_cdr), 0);
        check("rst_err", 32'(err), 0); check("rst_rdata", 32'(rdata), 0);
        check("rst_din", 32'(mem_data_in), 0);

        // car from requester 0, memory answers 3 cycles after the strobe
        step(); rst = 1'b1; req0 = 1'b1; op0 = 1'b0; wdata0 = 16'h0010;
        step(); sample();
        check("car_strobe", 32'(mem_car), 1); check("car_nocdr", 32'(mem_cdr), 0);
        check("car_din", 32'(mem_data_in), 32'h10);
        step(); sample(); check("car_onecycle", 32'(mem_car), 0);
        step();
        step(); mem_ready = 1'b1; mem_data_out = 16'h0042;
        sample(); check("car_noack_yet", 32'(ack0), 0);
        step(); mem_ready = 1'b0;
        sample();
        check("car_ack0", 32'(ack0), 1); check("car_ack1", 32'(ack1), 0);
        check("car_rdata", 32'(rdata), 32'h42); check("car_err", 32'(err), 0);
        step(); req0 = 1'b0;
        sample(); check("car_ack_pulse", 32'(ack0), 0);

        // reset in the middle of WAIT, then a late mem_ready
        step(); req0 = 1'b1; wdata0 = 16'h0033;
        step(); step(); step();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ack0", 32'(ack0), 0); check("mid_rst_ack1", 32'(ack1), 0);
        check("mid_rst_car", 32'(mem_car), 0); check("mid_rst_cdr", 32'(mem_cdr), 0);
        check("mid_rst_err", 32'(err), 0); check("mid_rst_rdata", 32'(rdata), 0);
        check("mid_rst_din", 32'(mem_data_in), 0);
        step(); rst = 1'b1; req0 = 1'b0; mem_ready = 1'b1; mem_data_out = 16'h0099;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("late_rdy_noack", 32'(ack0 | ack1), 0);
            check("late_rdy_nostrobe", 32'(mem_car | mem_cdr), 0);
            step(); mem_ready = 1'b0;
        end

        // tie after reset: both held, grants must alternate starting with 0
        req0 = 1'b1; op0 = 1'b0; wdata0 = 16'h00A0;
        req1 = 1'b1; op1 = 1'b1; wdata1 = 16'h00B1;
        n = 0; saw = 1'b0;
        for (int k = 0; k < 80 && n < 4; k++) begin
            step(); mem_ready = saw; mem_data_out = 16'(16'h5000 + k);
            sample();
            saw = mem_car | mem_cdr;
            check("tie_ack_excl", 32'(ack0 & ack1), 0);
            if (ack0 | ack1) begin got_order[n] = ack1 ? 1 : 0; n++; end
        end
        step(); req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        check("tie_ack_count", 32'(n), 4);
        for (int i = 0; i < 4; i++) check("tie_order", 32'(got_order[i]), 32'(exp_order[i]));

        // mem_ready while idle with no request
        for (int k = 0; k < 3; k++) begin
            step(); mem_ready = 1'b1; mem_data_out = 16'hDEAD;
            sample(); check("idle_rdy_noack", 32'(ack0 | ack1), 0);
        end
        step(); mem_ready = 1'b0;
        sample(); check("idle_rdy_nostrobe", 32'(mem_car | mem_cdr), 0);

        // cdr from requester 1
        step(); req1 = 1'b1; op1 = 1'b1; wdata1 = 16'h0123;
        step(); sample();
        check("cdr_strobe", 32'(mem_cdr), 1); check("cdr_nocar", 32'(mem_car), 0);
        check("cdr_din_cmd", 32'(mem_data_in), 32'h123);
        step(); sample(); check("cdr_din_wait", 32'(mem_data_in), 32'h123);
        step(); mem_ready = 1'b1; mem_data_out = 16'h0BEE;
        sample(); check("cdr_din_wait2", 32'(mem_data_in), 32'h123);
        step(); mem_ready = 1'b0;
        sample();
        check("cdr_ack1", 32'(ack1), 1); check("cdr_ack0", 32'(ack0), 0);
        check("cdr_rdata", 32'(rdata), 32'hBEE); check("cdr_err", 32'(err), 0);
        step(); req1 = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        timeout_run(1'b0, 16'h0000);
        timeout_run(1'b1, 16'h0077);
`endif

        // randomized phase: start from a reset so the model and DUT agree
        step(); rst = 1'b0;
        busy = 0; last = 1; prev_rst = 1; pend[0] = 0; pend[1] = 0;
        pop[0] = 0; pop[1] = 0; pdat[0] = '0; pdat[1] = '0;
        strobe_cyc = -10; ready_cyc = -10; ack_cyc = -10;
        chk_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (!rst) rst = 1'b1;
            if (busy && t == ack_cyc + 1) begin
                busy = 0; last = cur_id; pend[cur_id] = 0;
            end
            mem_data_out = 16'($urandom);
            if (!prev_rst && $urandom_range(0, 249) == 0) begin
                rst = 1'b0; prev_rst = 1;
                busy = 0; last = 1; pend[0] = 0; pend[1] = 0;
                req0 = 0; req1 = 0;
                mem_ready = 1'($urandom_range(0, 1));
                e_ack0 = 0; e_ack1 = 0; e_car = 0; e_cdr = 0;
                chk_rd = 1; e_rd = '0; e_err = 0;
                chk_din = 1; e_din = '0;
            end else begin
                prev_rst = 0;
                e_car   = busy && t == strobe_cyc && !cur_op;
                e_cdr   = busy && t == strobe_cyc && cur_op;
                e_ack0  = busy && t == ack_cyc && !cur_id;
                e_ack1  = busy && t == ack_cyc && cur_id;
                chk_rd  = busy && t == ack_cyc;
                e_rd    = ack_data; e_err = ack_err;
                chk_din = busy && t >= strobe_cyc && (ack_cyc < 0 || t < ack_cyc);
                e_din   = ptr;
                // memory responder
                mem_ready = 1'b0;
                if (busy && ack_cyc < 0 && t > strobe_cyc) begin
                    if (t == ready_cyc) begin
                        mem_ready = 1'b1; ack_cyc = t + 1;
                        ack_data = mem_data_out; ack_err = 0;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (t == strobe_cyc + TO) begin
                        ack_cyc = t + 1; ack_data = '0; ack_err = 1;
                    end
`endif
                end else if ($urandom_range(0, 3) == 0) begin
                    mem_ready = 1'b1;
                end
                // requesters hold their request until served
                for (int i = 0; i < 2; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1; pop[i] = 1'($urandom_range(0, 1));
                        pdat[i] = 16'($urandom);
                    end
                end
                req0 = pend[0]; op0 = pop[0]; wdata0 = pdat[0];
                req1 = pend[1]; op1 = pop[1]; wdata1 = pdat[1];
                // arbitration when idle
                if (!busy && (pend[0] || pend[1])) begin
                    if (pend[0] && pend[1]) cur_id = last ? 1'b0 : 1'b1;
                    else cur_id = pend[1];
                    busy = 1; cur_op = pop[cur_id]; ptr = pdat[cur_id];
                    strobe_cyc = t + 1;
                    ready_cyc = t + 1 + $urandom_range(1, MAXD);
                    ack_cyc = -1;
                end
            end
        end
        step(); chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default `memory_data_width, width of all data/address buses.
REQ-002 Parameter TIMEOUT, default 255, WAIT-state cycle limit (used only with MEM_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  request, requester 0/1; held high until ack.
REQ-006 op0, op1  input  1 each  0 = car, 1 = cdr; stable while req high.
REQ-007 wdata0, wdata1  input  DATA_W each  cell pointer for memory; stable while req high.
REQ-008 ack0, ack1  output  1 each  one-cycle completion strobe to requester.
REQ-009 rdata  output  DATA_W  result, valid only while ack0 or ack1 high.
REQ-010 err  output  1  abort flag, valid only with ack.
REQ-011 mem_car, mem_cdr  output  1 each  one-cycle command strobes to memory unit.
REQ-012 mem_data_in  output  DATA_W  pointer to memory unit, held from CMD until WAIT exits.
REQ-013 mem_data_out  input  DATA_W  memory result, valid when mem_ready high.
REQ-014 mem_ready  input  1  one-cycle completion strobe from memory unit.

Function
REQ-015 FSM states IDLE, CMD, WAIT, ACK; at most one memory transaction outstanding.
REQ-016 IDLE: any req high -> latch winner id, op, wdata; go CMD next cycle; else stay.
REQ-017 Arbitration round-robin: single requester wins; both high -> grant requester not served last.
REQ-018 last-served flag resets to 1 so requester 0 wins the first tie.
REQ-019 CMD: exactly one of mem_car (op=0) / mem_cdr (op=1) high for one cycle; mem_data_in = latched wdata; go WAIT.
REQ-020 WAIT: mem_ready high -> register mem_data_out into rdata, go ACK; else stay.
REQ-021 mem_ready in IDLE, CMD or ACK ignored.
REQ-022 ACK: ack of winner high one cycle, other ack low, rdata stable; update last-served; go IDLE.
REQ-023 Latency: req sampled in IDLE cycle N -> strobe cycle N+1; mem_ready cycle M -> ack cycle M+1.
REQ-024 Requester still asserting req in cycle after ack = new request, arbitrated normally.
REQ-025 Loser req stays pending unchanged; no starvation: pending requester served within two transactions.
REQ-026 ack0 and ack1 never high together; mem_car and mem_cdr never high together.
REQ-027 rdata, err hold last value outside ACK; not required to be meaningful.

Reset
REQ-028 rst low forces IDLE immediately, asynchronously, in any state incl. mid-WAIT.
REQ-029 Reset values: ack0=ack1=0, mem_car=mem_cdr=0, err=0, rdata=0, mem_data_in=0, last-served=1, counter=0.
REQ-030 Transaction in flight at reset is discarded; no ack issued; late mem_ready ignored.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle; reaching TIMEOUT without mem_ready -> ACK with rdata=0, err=1.
REQ-032 mem_ready in same cycle counter reaches TIMEOUT: normal completion wins, err=0.
REQ-033 Macro undefined: no counter, WAIT waits indefinitely, err tied 0, TIMEOUT unused.

Verification
REQ-034 req0=1 op0=0 wdata0=0x0010, mem_ready 3 cycles after mem_car with data 0x0042 -> mem_car one cycle, ack0 one cycle later, rdata=0x0042, err=0.
REQ-035 req0 and req1 high same cycle after reset, both held -> grant order 0,1,0,1; ack pulses alternate, ack0/ack1 never together.
REQ-036 req1=1 op1=1 wdata1=0x0123 -> mem_cdr only, mem_data_in=0x0123 through WAIT, ack1 with memory data.
REQ-037 rst low during WAIT, then mem_ready pulse after release -> no ack, state IDLE, all outputs 0.
REQ-038 MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ready never -> ack after 8 WAIT cycles, err=1, rdata=0; mem_ready on cycle 8 -> err=0, rdata=memory data.
REQ-039 mem_ready pulsed while IDLE with no req -> no ack, no state change.
